// File: rtl/disp_pkg.sv
// Shared types for the stereo SAD disparity matcher.
// Pixel/window geometry, SAD width and the per-pixel absolute difference.
package disp_pkg;

   localparam int PIX_W = 8;
   localparam int WIN   = 5;
   localparam int SAD_W = 13;

   typedef logic [WIN*PIX_W-1:0] pix_row_t;
   typedef pix_row_t [WIN-1:0]   win_t;
   typedef logic [SAD_W-1:0]     sad_t;

   // 9-bit unsigned |a-b|
   function automatic logic [PIX_W:0] abs_diff(
      input logic [PIX_W-1:0] a,
      input logic [PIX_W-1:0] b
   );
      if (a >= b)
         return {1'b0, a} - {1'b0, b};
      else
         return {1'b0, b} - {1'b0, a};
   endfunction

endpackage

// File: rtl/sad_5x5.sv
// Combinational sum of absolute differences over one 5x5 window pair.
// Ports: win_l, win_r (5 rows of 5 pixels each) in; sad (13 bits) out.
import disp_pkg::*;

module sad_5x5 (
   input  win_t win_l,
   input  win_t win_r,
   output sad_t sad
);

   always_comb begin
      sad = '0;
      for (int r = 0; r < WIN; r++) begin
         for (int k = 0; k < WIN; k++) begin
            sad = sad + sad_t'(abs_diff(win_l[r][k*PIX_W +: PIX_W],
                                        win_r[r][k*PIX_W +: PIX_W]));
         end
      end
   end

endmodule

// File: rtl/sad_disparity_matcher.sv
// Block-matching disparity: SAD of the left window against MAX_DISP past
// right windows, argmin over the candidates valid in the current line.
// Ports: i_clk, rst_n (async, active low), i_valid, i_sol,
//   i_vector_l_1..5 / i_vector_r_1..5 (40-bit window rows) in;
//   o_valid, o_disp, o_min_sad, o_conf out. Latency 2 cycles.
// Option: define SAD_UNIQ_EN to build the second-minimum uniqueness test;
//   otherwise o_conf is constant 1 out of reset.
import disp_pkg::*;

module sad_disparity_matcher #(
   parameter int MAX_DISP = 16,
   parameter int DISP_W   = $clog2(MAX_DISP),
   parameter int UNIQ_TH  = 8
) (
   input  logic              i_clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic              i_sol,
   input  logic [39:0]       i_vector_l_1,
   input  logic [39:0]       i_vector_l_2,
   input  logic [39:0]       i_vector_l_3,
   input  logic [39:0]       i_vector_l_4,
   input  logic [39:0]       i_vector_l_5,
   input  logic [39:0]       i_vector_r_1,
   input  logic [39:0]       i_vector_r_2,
   input  logic [39:0]       i_vector_r_3,
   input  logic [39:0]       i_vector_r_4,
   input  logic [39:0]       i_vector_r_5,
   output logic              o_valid,
   output logic [DISP_W-1:0] o_disp,
   output logic [12:0]       o_min_sad,
   output logic              o_conf
);

   win_t win_l;
   win_t win_r;

   assign win_l = {i_vector_l_5, i_vector_l_4, i_vector_l_3,
                   i_vector_l_2, i_vector_l_1};
   assign win_r = {i_vector_r_5, i_vector_r_4, i_vector_r_3,
                   i_vector_r_2, i_vector_r_1};

   // Right-window history and line fill counter
   win_t              hist [MAX_DISP-1];
   logic [DISP_W-1:0] hcnt;
   logic [DISP_W-1:0] eff;

   // A start-of-line column only trusts d=0; stale history stays masked
   assign eff = i_sol ? '0 : hcnt;

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_DISP-1; i++)
            hist[i] <= '0;
         hcnt <= '0;
      end else if (i_valid) begin
         hist[0] <= win_r;
         for (int i = 1; i < MAX_DISP-1; i++)
            hist[i] <= hist[i-1];
         if (i_sol)
            hcnt <= DISP_W'(1);
         else if (hcnt != DISP_W'(MAX_DISP-1))
            hcnt <= hcnt + 1'b1;
      end
   end

   // Candidate SADs
   sad_t              sad_c  [MAX_DISP];
   logic [MAX_DISP-1:0] mask_c;

   for (genvar d = 0; d < MAX_DISP; d++) begin : g_cand
      win_t cand;
      if (d == 0) begin : g_cur
         assign cand = win_r;
      end else begin : g_hist
         assign cand = hist[d-1];
      end
      assign mask_c[d] = (DISP_W'(d) <= eff);
      sad_5x5 u_sad (
         .win_l (win_l),
         .win_r (cand),
         .sad   (sad_c[d])
      );
   end

   // Stage 1
   logic                s1_valid;
   logic [MAX_DISP-1:0] s1_mask;
   sad_t                s1_sad [MAX_DISP];

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_mask  <= '0;
         for (int d = 0; d < MAX_DISP; d++)
            s1_sad[d] <= '0;
      end else begin
         s1_valid <= i_valid;
         if (i_valid) begin
            s1_mask <= mask_c;
            for (int d = 0; d < MAX_DISP; d++)
               s1_sad[d] <= sad_c[d];
         end
      end
   end

   // Argmin; strict compare keeps the smallest d on ties
   sad_t              best_sad;
   logic [DISP_W-1:0] best_idx;

   always_comb begin
      best_sad = s1_sad[0];
      best_idx = '0;
      for (int d = 1; d < MAX_DISP; d++) begin
         if (s1_mask[d] && (s1_sad[d] < best_sad)) begin
            best_sad = s1_sad[d];
            best_idx = DISP_W'(d);
         end
      end
   end

`ifdef SAD_UNIQ_EN
   sad_t sec_sad;
   logic sec_any;
   logic conf_c;

   always_comb begin
      sec_sad = '1;
      sec_any = 1'b0;
      for (int d = 0; d < MAX_DISP; d++) begin
         if (s1_mask[d] && (DISP_W'(d) != best_idx)) begin
            sec_any = 1'b1;
            if (s1_sad[d] < sec_sad)
               sec_sad = s1_sad[d];
         end
      end
      conf_c = !sec_any ||
               ((sec_sad - best_sad) >= sad_t'(UNIQ_TH));
   end
`else
   logic unused_th;
   assign unused_th = ^UNIQ_TH;
`endif

   // Stage 2
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid   <= 1'b0;
         o_disp    <= '0;
         o_min_sad <= '0;
         o_conf    <= 1'b0;
      end else begin
         o_valid <= s1_valid;
         if (s1_valid) begin
            o_disp    <= best_idx;
            o_min_sad <= best_sad;
         end
`ifdef SAD_UNIQ_EN
         if (s1_valid)
            o_conf <= conf_c;
`else
         o_conf <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_sad_disparity_matcher.sv
// Scoreboard bench for sad_disparity_matcher: directed line scenarios plus
// randomized windows checked against a per-column reference model.
module tb_sad_disparity_matcher;

   localparam int MD = 16;
   localparam int UT = 8;

   typedef logic [199:0] w_t;
   typedef struct {
      int disp;
      int sad;
      int conf;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic        i_sol;
   logic [39:0] vl1, vl2, vl3, vl4, vl5;
   logic [39:0] vr1, vr2, vr3, vr4, vr5;
   logic        o_valid;
   logic [3:0]  o_disp;
   logic [12:0] o_min_sad;
   logic        o_conf;

   int   cyc = 0;
   int   total = 0;
   int   passed = 0;
   exp_t expq[$];
   w_t   rhist[$];
   int   col;

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   sad_disparity_matcher #(.MAX_DISP(MD), .UNIQ_TH(UT)) dut (
      .i_clk        (clk),
      .rst_n        (rst_n),
      .i_valid      (i_valid),
      .i_sol        (i_sol),
      .i_vector_l_1 (vl1),
      .i_vector_l_2 (vl2),
      .i_vector_l_3 (vl3),
      .i_vector_l_4 (vl4),
      .i_vector_l_5 (vl5),
      .i_vector_r_1 (vr1),
      .i_vector_r_2 (vr2),
      .i_vector_r_3 (vr3),
      .i_vector_r_4 (vr4),
      .i_vector_r_5 (vr5),
      .o_valid      (o_valid),
      .o_disp       (o_disp),
      .o_min_sad    (o_min_sad),
      .o_conf       (o_conf)
   );

   task automatic check(input string n, input int act, input int exp);
      total++;
      if (act == exp)
         passed++;
      else
         $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  n, act, exp, $time);
   endtask

   function automatic int sad_of(input w_t a, input w_t b);
      int s = 0;
      for (int i = 0; i < 25; i++) begin
         int pa = int'(a[i*8 +: 8]);
         int pb = int'(b[i*8 +: 8]);
         s += (pa > pb) ? pa - pb : pb - pa;
      end
      return s;
   endfunction

   function automatic w_t fillw(input int v);
      w_t w;
      for (int i = 0; i < 25; i++) w[i*8 +: 8] = 8'(v);
      return w;
   endfunction

   function automatic w_t randw();
      w_t w;
      for (int i = 0; i < 25; i++) w[i*8 +: 8] = 8'($urandom);
      return w;
   endfunction

   // window of image column x where image pixel = base + column
   function automatic w_t rampw(input int base);
      w_t w;
      for (int r = 0; r < 5; r++)
         for (int k = 0; k < 5; k++)
            w[(r*5+k)*8 +: 8] = 8'(base - 2 + k);
      return w;
   endfunction

   task automatic model_reset();
      rhist.delete();
      for (int i = 0; i < MD-1; i++) rhist.push_back('0);
      col = 0;
      expq.delete();
   endtask

   // Issue one column; expected result derived from line position
   task automatic send(input w_t lw, input w_t rw, input bit sol);
      int   s [MD];
      int   hc, best, bi, sec;
      bit   any2;
      exp_t e;
      hc = sol ? 0 : col;
      for (int d = 0; d <= hc; d++)
         s[d] = sad_of(lw, (d == 0) ? rw : rhist[d-1]);
      best = s[0];
      bi = 0;
      for (int d = 1; d <= hc; d++)
         if (s[d] < best) begin
            best = s[d];
            bi = d;
         end
      sec = 1 << 30;
      any2 = 1'b0;
      for (int d = 0; d <= hc; d++)
         if (d != bi) begin
            any2 = 1'b1;
            if (s[d] < sec) sec = s[d];
         end
      e.disp = bi;
      e.sad  = best;
`ifdef SAD_UNIQ_EN
      e.conf = (!any2 || (sec - best >= UT)) ? 1 : 0;
`else
      e.conf = 1;
`endif
      e.cyc = cyc;
      expq.push_back(e);
      rhist.push_front(rw);
      void'(rhist.pop_back());
      col = sol ? 1 : ((col < MD-1) ? col + 1 : col);
      i_valid = 1'b1;
      i_sol   = sol;
      {vl5, vl4, vl3, vl2, vl1} = lw;
      {vr5, vr4, vr3, vr2, vr1} = rw;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_sol   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && o_valid) begin
            if (expq.size() == 0) begin
               total++;
               $display("FAIL unexpected_valid: got o_valid=1 expected none");
            end else begin
               e = expq.pop_front();
               check("latency", cyc - e.cyc, 2);
               check("disp", int'(o_disp), e.disp);
               check("min_sad", int'(o_min_sad), e.sad);
               check("conf", int'(o_conf), e.conf);
            end
         end
      end
   end

   initial begin
      w_t lw, rw, a;
      int wait_n;
      rst_n = 1'b0;
      i_valid = 1'b0;
      i_sol = 1'b0;
      {vl5, vl4, vl3, vl2, vl1} = '0;
      {vr5, vr4, vr3, vr2, vr1} = '0;
      model_reset();
      idle(3);
      check("rst_valid", int'(o_valid), 0);
      check("rst_disp", int'(o_disp), 0);
      check("rst_sad", int'(o_min_sad), 0);
      check("rst_conf", int'(o_conf), 0);
      rst_n = 1'b1;
      idle(1);

      // constant images
      for (int x = 0; x < 40; x++)
         send(fillw(8'h40), fillw(8'h40), x == 0);
      idle(3);

      // true shift of 3
      for (int x = 0; x < 40; x++)
         send(rampw(17 + x), rampw(20 + x), x == 0);
      idle(2);

      // line restart with a stale zero-SAD match at d=5
      for (int x = 0; x < 8; x++)
         send(randw(), randw(), x == 0);
      send(randw(), randw(), 1'b1);
      send(rhist[4], randw(), 1'b0);
      send(rhist[4], randw(), 1'b0);
      idle(2);

      // extremes
      for (int x = 0; x < 20; x++)
         send(fillw(8'hFF), fillw(8'h00), x == 0);
      idle(2);

      // uniqueness: best 100 at d=2, second 104 then 110 at d=6
      for (int m = 0; m < 2; m++) begin
         for (int x = 0; x < 7; x++) begin
            rw = fillw(128);
            rw[7:0] = (x == 0) ? ((m == 0) ? 8'd24 : 8'd18)
                    : (x == 4) ? 8'd28 : 8'd0;
            send(fillw(128), rw, x == 0);
         end
         idle(1);
      end
      idle(2);

      // reset with a column in flight
      a = randw();
      send(randw(), randw(), 1'b1);
      send(randw(), a, 1'b0);
      rst_n = 1'b0;
      model_reset();
      idle(1);
      check("inflight_valid", int'(o_valid), 0);
      rst_n = 1'b1;
      idle(2);
      check("post_rst_valid", int'(o_valid), 0);
      send(a, randw(), 1'b0);
      send(a, randw(), 1'b0);
      idle(3);

      // randomized stream
      for (int n = 0; n < 300; n++) begin
         rw = randw();
         if ($urandom_range(0, 1) == 1)
            lw = rhist[$urandom_range(0, MD-2)];
         else
            lw = randw();
         if ($urandom_range(0, 3) == 0)
            lw[$urandom_range(0, 24)*8 +: 8] = 8'($urandom);
         send(lw, rw, $urandom_range(0, 24) == 0);
         if ($urandom_range(0, 3) == 0)
            idle($urandom_range(1, 3));
      end

      wait_n = 0;
      while (expq.size() > 0 && wait_n < 20) begin
         @(posedge clk);
         wait_n++;
      end
      @(negedge clk);
      check("drain", expq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
